// File: rtl/lsu_mem_port.sv
// Load/store port between the execute stage and a little-endian byte-lane memory.
// Checks alignment, maps byte/half/word stores onto active-low lane enables with
// lane-shifted data, and returns sign/zero-extended load data with a one-cycle pulse.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | ready for a request; req_ready high while out of reset
// S_WRITE     | one cycle with the store lane enables driven low
// S_READ      | mem_addr presented to memory
// S_READ_WAIT | memory read data arriving, captured at the end of this cycle
// S_RESP      | resp_valid pulse, resp_err/resp_rdata valid
module lsu_mem_port #(
    parameter int ADDR_WIDTH       = 12,
    parameter int DATA_WIDTH_BYTES = 4
) (
    input  logic                             clk,
    input  logic                             rstL,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [1:0]                       req_size,
    input  logic                             req_unsigned,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [31:0]                      req_wdata,
    output logic                             resp_valid,
    output logic                             resp_err,
    output logic [31:0]                      resp_rdata,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH_BYTES-1:0]      mem_wenableL,
    output logic [DATA_WIDTH_BYTES-1:0][7:0] mem_data_w,
    input  logic [DATA_WIDTH_BYTES-1:0][7:0] mem_data_r
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ      = 3'd2,
        S_READ_WAIT = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_addr_lo;

    logic        w_accept;
    logic        w_misaligned;
    logic [3:0]  w_lane_mask;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_rword;
    logic [31:0] w_rsh;
    logic [31:0] w_load;

    logic [DATA_WIDTH_BYTES-1:0]      w_wen_nxt;
    logic [DATA_WIDTH_BYTES-1:0][7:0] w_dw_nxt;
    logic [ADDR_WIDTH-1:0]            w_addr_nxt;
    logic                             w_rv_nxt;
    logic                             w_err_nxt;
    logic [31:0]                      w_rd_nxt;

    // Ready is gated by reset so nothing upstream can hand us a request while held in reset.
    assign req_ready = (r_state == S_IDLE) && rstL;
    assign w_accept  = req_valid && req_ready;

    assign w_misaligned = (req_size == 2'b11) ||
                          ((req_size == 2'b01) && req_addr[0]) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // Store data moves to its lanes by a byte shift; aligned accesses never spill past lane 3.
    assign w_wdata_sh = req_wdata << {req_addr[1:0], 3'b000};
    assign w_rword    = mem_data_r;
    assign w_rsh      = w_rword >> {r_addr_lo, 3'b000};

    // Lane enable pattern for the incoming store.
    always_comb begin
        w_lane_mask = 4'b0000;
        case (req_size)
            2'b00:   w_lane_mask = 4'b0001 << req_addr[1:0];
            2'b01:   w_lane_mask = 4'b0011 << req_addr[1:0];
            2'b10:   w_lane_mask = 4'b1111;
            default: w_lane_mask = 4'b0000;
        endcase
    end

    // Extract and extend the load result from the returned word.
    always_comb begin
        w_load = w_rsh;
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'h0, w_rsh[7:0]}
                                         : {{24{w_rsh[7]}}, w_rsh[7:0]};
            2'b01:   w_load = r_unsigned ? {16'h0, w_rsh[15:0]}
                                         : {{16{w_rsh[15]}}, w_rsh[15:0]};
            default: w_load = w_rsh;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode; errors skip memory entirely and go straight to the response.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) w_state_nxt = S_RESP;
                    else if (req_we)  w_state_nxt = S_WRITE;
                    else              w_state_nxt = S_READ;
                end
            end
            S_WRITE:     w_state_nxt = S_RESP;
            S_READ:      w_state_nxt = S_READ_WAIT;
            S_READ_WAIT: w_state_nxt = S_RESP;
            S_RESP:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; enables are low only for the cycle spent in S_WRITE.
    always_comb begin
        w_wen_nxt  = '1;
        w_dw_nxt   = '0;
        w_addr_nxt = mem_addr;
        w_rv_nxt   = 1'b0;
        w_err_nxt  = resp_err;
        w_rd_nxt   = resp_rdata;
        if (w_accept && !w_misaligned) begin
            w_addr_nxt = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (req_we) begin
                w_wen_nxt = ~w_lane_mask;
                for (int k = 0; k < DATA_WIDTH_BYTES; k++) begin
                    w_dw_nxt[k] = w_lane_mask[k] ? w_wdata_sh[8*k +: 8] : 8'h00;
                end
            end
        end
        if ((w_state_nxt == S_RESP) && (r_state != S_RESP)) begin
            w_rv_nxt  = 1'b1;
            w_err_nxt = (r_state == S_IDLE);
            w_rd_nxt  = (r_state == S_READ_WAIT) ? w_load : 32'h0;
        end
    end

    // Output and request-field registers; reset forces every lane enable inactive at once.
    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) begin
            mem_wenableL <= '1;
            mem_data_w   <= '0;
            mem_addr     <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr_lo    <= 2'b00;
        end else begin
            mem_wenableL <= w_wen_nxt;
            mem_data_w   <= w_dw_nxt;
            mem_addr     <= w_addr_nxt;
            resp_valid   <= w_rv_nxt;
            resp_err     <= w_err_nxt;
            resp_rdata   <= w_rd_nxt;
            if (w_accept) begin
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr_lo  <= req_addr[1:0];
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: behavioural byte memory, directed vector table,
// reset corner cases and randomized traffic against a byte-array reference.
module tb_lsu_mem_port;

    logic              clk;
    logic              rstL;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [11:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic [11:0]       mem_addr;
    logic [3:0]        mem_wenableL;
    logic [3:0][7:0]   mem_data_w;
    logic [3:0][7:0]   mem_data_r;

    lsu_mem_port #(.ADDR_WIDTH(12), .DATA_WIDTH_BYTES(4)) dut (
        .clk          (clk),
        .rstL         (rstL),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_wenableL (mem_wenableL),
        .mem_data_w   (mem_data_w),
        .mem_data_r   (mem_data_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory the DUT talks to: synchronous lane writes, registered read data.
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!mem_wenableL[k]) mem[int'(mem_addr) + k] <= mem_data_w[k];
            mem_data_r[k] <= mem[int'(mem_addr) + k];
        end
    end

    // Reference memory, updated only from the architectural meaning of each request.
    logic [7:0] ref_mem [0:4095];

    int n_cmp;
    int n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ref_exec(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [11:0] addr, input logic [31:0] wd,
                            output logic e_err, output logic [31:0] e_rd, output int e_lat,
                            output logic [3:0] e_wen, output logic [31:0] e_dw);
        int     n;
        int     a;
        longint m;
        longint v;
        a     = int'(addr) % 4;
        n     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        e_err = (sz == 2'b11) || ((int'(addr) % n) != 0);
        e_rd  = 32'h0;
        e_wen = 4'hF;
        e_dw  = 32'h0;
        m     = (64'd1 << (8 * n)) - 1;
        if (e_err) begin
            e_lat = 1;
        end else if (we) begin
            e_lat = 2;
            for (int j = 0; j < n; j++) ref_mem[int'(addr) + j] = 8'((wd >> (8 * j)) & 32'hFF);
            e_wen = ~(4'((64'd1 << n) - 1) << a);
            e_dw  = 32'((longint'(wd) & m) << (8 * a));
        end else begin
            e_lat = 3;
            v = 0;
            for (int j = 0; j < n; j++) v = v | (longint'(ref_mem[int'(addr) + j]) << (8 * j));
            if (!uns && (((v >> (8 * n - 1)) & 1) == 1)) v = v | ~m;
            e_rd = 32'(v);
        end
    endtask

    // One request; after acceptance req_valid stays high with junk to confirm it is ignored.
    task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wd,
                          output logic rdy, output logic rv_before, output int lat,
                          output logic err, output logic [31:0] rd, output logic [3:0] wen_and,
                          output logic [31:0] dw, output int wcyc, output logic [11:0] maddr);
        @(negedge clk);
        rdy          = req_ready;
        rv_before    = resp_valid;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = 12'($urandom);
        req_wdata    = $urandom;
        lat     = 0;
        err     = 1'b0;
        rd      = 32'h0;
        wen_and = 4'hF;
        dw      = 32'h0;
        wcyc    = 0;
        maddr   = 12'h0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            wen_and = wen_and & mem_wenableL;
            if (mem_wenableL != 4'hF) begin
                wcyc++;
                dw = mem_data_w;
            end
            if (resp_valid) begin
                err   = resp_err;
                rd    = resp_rdata;
                maddr = mem_addr;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        logic [3:0]  e_wen;
        logic [31:0] e_dw;
        logic [11:0] e_maddr;
    } vec_t;

    vec_t vecs [13];

    logic        o_rdy, o_rv0, o_err;
    logic [31:0] o_rd, o_dw;
    logic [3:0]  o_wen;
    logic [11:0] o_maddr;
    int          o_lat, o_wcyc;
    logic        r_err;
    logic [31:0] r_rd, r_dw;
    logic [3:0]  r_wen;
    int          r_lat;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem_data_r = '0;

        //         we  sz     uns addr     wdata         err rdata         lat wen   data_w        maddr
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 32'h00000000, 2, 4'h0, 32'hDEADBEEF, 12'h010};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        1'b0, 32'hDEADBEEF, 3, 4'hF, 32'h0,        12'h010};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 12'h013, 32'h000000A5, 1'b0, 32'h00000000, 2, 4'h7, 32'hA5000000, 12'h010};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 12'h013, 32'h0,        1'b0, 32'hFFFFFFA5, 3, 4'hF, 32'h0,        12'h010};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        1'b0, 32'h000000A5, 3, 4'hF, 32'h0,        12'h010};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 12'h012, 32'h00008001, 1'b0, 32'h00000000, 2, 4'h3, 32'h80010000, 12'h010};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 12'h012, 32'h0,        1'b0, 32'hFFFF8001, 3, 4'hF, 32'h0,        12'h010};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 12'h012, 32'h0,        1'b0, 32'h00008001, 3, 4'hF, 32'h0,        12'h010};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        1'b0, 32'h8001BEEF, 3, 4'hF, 32'h0,        12'h010};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 12'h011, 32'h0,        1'b1, 32'h00000000, 1, 4'hF, 32'h0,        12'h010};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 12'h013, 32'h00001234, 1'b1, 32'h00000000, 1, 4'hF, 32'h0,        12'h010};
        vecs[11] = '{1'b1, 2'b11, 1'b0, 12'h010, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1, 4'hF, 32'h0,        12'h010};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        1'b0, 32'h8001BEEF, 3, 4'hF, 32'h0,        12'h010};

        // Reset held with a request pending.
        rstL         = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 12'h010;
        req_wdata    = 32'h11223344;
        repeat (3) @(negedge clk);
        chk("rst_wenableL",   32'(mem_wenableL), 32'hF);
        chk("rst_resp_valid", 32'(resp_valid),   32'h0);
        chk("rst_req_ready",  32'(req_ready),    32'h0);
        chk("rst_mem_addr",   32'(mem_addr),     32'h0);
        chk("rst_data_w",     32'(mem_data_w),   32'h0);
        chk("rst_resp_rdata", resp_rdata,        32'h0);
        req_valid = 1'b0;
        rstL      = 1'b1;

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                   o_rdy, o_rv0, o_lat, o_err, o_rd, o_wen, o_dw, o_wcyc, o_maddr);
            ref_exec(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                     r_err, r_rd, r_lat, r_wen, r_dw);
            chk($sformatf("v%0d_ready", i),   32'(o_rdy),   32'h1);
            chk($sformatf("v%0d_pulse", i),   32'(o_rv0),   32'h0);
            chk($sformatf("v%0d_latency", i), 32'(o_lat),   32'(vecs[i].e_lat));
            chk($sformatf("v%0d_err", i),     32'(o_err),   32'(vecs[i].e_err));
            chk($sformatf("v%0d_rdata", i),   o_rd,         vecs[i].e_rd);
            chk($sformatf("v%0d_wen", i),     32'(o_wen),   32'(vecs[i].e_wen));
            chk($sformatf("v%0d_wcycles", i), 32'(o_wcyc),  (vecs[i].e_wen != 4'hF) ? 32'h1 : 32'h0);
            chk($sformatf("v%0d_mem_addr", i), 32'(o_maddr), 32'(vecs[i].e_maddr));
            if (vecs[i].we && !vecs[i].e_err) chk($sformatf("v%0d_data_w", i), o_dw, vecs[i].e_dw);
        end

        // Reset dropped in the WRITE cycle of SW@0x020 aborts the store.
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'h1);
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 12'h020;
        req_wdata    = 32'h12345678;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_write_started", 32'(mem_wenableL), 32'h0);
        #1;
        rstL = 1'b0;
        #1;
        chk("abort_wen_immediate", 32'(mem_wenableL), 32'hF);
        chk("abort_ready_low",     32'(req_ready),    32'h0);
        @(negedge clk);
        chk("abort_wen_held", 32'(mem_wenableL), 32'hF);
        @(negedge clk);
        rstL = 1'b1;
        chk("abort_mem_untouched",
            {mem[12'h023], mem[12'h022], mem[12'h021], mem[12'h020]}, 32'h0);
        run_op(1'b0, 2'b10, 1'b0, 12'h020, 32'h0,
               o_rdy, o_rv0, o_lat, o_err, o_rd, o_wen, o_dw, o_wcyc, o_maddr);
        chk("abort_next_ready",   32'(o_rdy), 32'h1);
        chk("abort_next_latency", 32'(o_lat), 32'h3);
        chk("abort_next_err",     32'(o_err), 32'h0);
        chk("abort_next_rdata",   o_rd,       32'h0);

        // Randomized traffic against the reference memory.
        for (int i = 0; i < 300; i++) begin
            logic        we, uns;
            logic [1:0]  sz;
            logic [11:0] addr;
            logic [31:0] wd;
            we   = 1'($urandom);
            sz   = 2'($urandom);
            uns  = 1'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? 12'(12'hFC0 + $urandom_range(0, 63))
                                               : 12'($urandom_range(0, 63));
            wd   = $urandom;
            run_op(we, sz, uns, addr, wd,
                   o_rdy, o_rv0, o_lat, o_err, o_rd, o_wen, o_dw, o_wcyc, o_maddr);
            ref_exec(we, sz, uns, addr, wd, r_err, r_rd, r_lat, r_wen, r_dw);
            chk($sformatf("r%0d_ready", i),   32'(o_rdy), 32'h1);
            chk($sformatf("r%0d_latency", i), 32'(o_lat), 32'(r_lat));
            chk($sformatf("r%0d_err", i),     32'(o_err), 32'(r_err));
            chk($sformatf("r%0d_rdata", i),   o_rd,       r_rd);
            chk($sformatf("r%0d_wen", i),     32'(o_wen), 32'(r_wen));
            if (we && !r_err) chk($sformatf("r%0d_data_w", i), o_dw, r_dw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
